soc_boot_ctrl: RTL and testbench

Boot and run sequencer for the single-core SoC. After start, it streams a program image into instruction memory and holds the core in reset while loading. It then releases the core, enables fetch, and watches the completion flag word. It reports the result word and the cycle count on completion, or raises a timeout if the run does not finish.

---
 rtl/soc_boot_pkg.sv | 46 ++++
 rtl/boot_run_timer.sv | 61 ++++++
 rtl/soc_boot_ctrl.sv | 148 ++++++++++++++
 tb/tb_soc_boot_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_boot_pkg.sv
// Shared types for the SoC boot/run sequencer.
// Defining BOOT_SCRUB_EN adds the SCRUB state, which NOP-fills instruction memory before loading.
package soc_boot_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
`ifdef BOOT_SCRUB_EN
      ST_SCRUB   = 3'd1,
`endif
      ST_LOAD    = 3'd2,
      ST_RELEASE = 3'd3,
      ST_RUN     = 3'd4,
      ST_DONE    = 3'd5,
      ST_TIMEOUT = 3'd6
   } boot_state_e;

   typedef struct packed {
      logic ld_ready;
      logic core_rst_n;
      logic fetch_en;
      logic busy;
      logic done;
      logic timeout;
   } boot_out_t;

   // Moore outputs for a given state; these are registered together with the state.
   function automatic boot_out_t boot_outs(input boot_state_e s);
      boot_out_t o;
      o = '0;
      case (s)
`ifdef BOOT_SCRUB_EN
         ST_SCRUB:   o.busy = 1'b1;
`endif
         ST_LOAD:    begin o.ld_ready = 1'b1; o.busy = 1'b1; end
         ST_RELEASE: begin o.core_rst_n = 1'b1; o.busy = 1'b1; end
         ST_RUN:     begin o.core_rst_n = 1'b1; o.fetch_en = 1'b1; o.busy = 1'b1; end
         ST_DONE:    begin o.core_rst_n = 1'b1; o.done = 1'b1; end
         ST_TIMEOUT: begin o.core_rst_n = 1'b1; o.timeout = 1'b1; end
         default:    o = '0;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/boot_run_timer.sv
// RUN-phase cycle counter with a down-counting timeout terminal count.
// Captures the result word and cycle count on completion or timeout.
module boot_run_timer
   import soc_boot_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_cnt_i,
   input  logic        clr_cap_i,
   input  logic        run_i,
   input  logic [31:0] mem_flag_i,
   input  logic [31:0] mem_result_i,
   output logic        flag_hit_o,
   output logic        timeout_hit_o,
   output logic [31:0] result_o,
   output logic [31:0] cycles_o
);

   localparam logic [31:0] TC_LOAD   = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] TC_CYCLES = 32'(TIMEOUT_CYCLES);

   logic [31:0] run_cnt;
   logic [31:0] run_cnt_inc;
   logic [31:0] tc_remain;

   assign run_cnt_inc   = (run_cnt == '1) ? run_cnt : run_cnt + 32'd1;
   assign flag_hit_o    = run_i && (mem_flag_i != '0);
   // A nonzero flag in the terminal cycle takes priority over the timeout.
   assign timeout_hit_o = run_i && (mem_flag_i == '0) && (tc_remain == '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_cnt   <= '0;
         tc_remain <= TC_LOAD;
         result_o  <= '0;
         cycles_o  <= '0;
      end else begin
         if (clr_cnt_i) begin
            run_cnt   <= '0;
            tc_remain <= TC_LOAD;
         end else if (run_i) begin
            run_cnt <= run_cnt_inc;
            if (tc_remain != '0)
               tc_remain <= tc_remain - 32'd1;
         end

         if (clr_cap_i) begin
            result_o <= '0;
            cycles_o <= '0;
         end else if (flag_hit_o) begin
            result_o <= mem_result_i;
            cycles_o <= run_cnt_inc;
         end else if (timeout_hit_o) begin
            cycles_o <= TC_CYCLES;
         end
      end
   end

endmodule

// File: rtl/soc_boot_ctrl.sv
// Boot/run sequencer: loads the program image, releases the core and watches for completion.
// Optional BOOT_SCRUB_EN: NOP-fill all of instruction memory before each load.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | core held in reset, waiting for start
// SCRUB      | (BOOT_SCRUB_EN) writing NOP to every imem word
// LOAD       | accepting loader words into imem, core in reset
// RELEASE    | one cycle: core out of reset, fetch still off, run timer cleared
// RUN        | fetch enabled, watching completion flag and timeout
// DONE       | flag seen; result and cycle count held
// TIMEOUT    | run did not finish in time; cycle count held
module soc_boot_ctrl
   import soc_boot_pkg::*;
#(
   parameter int          IMEM_DEPTH     = 256,
   parameter int          ADDR_W         = 8,
   parameter int unsigned TIMEOUT_CYCLES = 100
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              ld_valid_i,
   input  logic [31:0]       ld_data_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              core_rst_no,
   output logic              fetch_enable_o,
   input  logic [31:0]       mem_flag_i,
   input  logic [31:0]       mem_result_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              timeout_o,
   output logic [31:0]       result_o,
   output logic [31:0]       cycles_o
);

   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMEM_DEPTH - 1);

   boot_state_e       state;
   boot_out_t         outs;
   logic [ADDR_W-1:0] addr_cnt;
   logic              ld_accept;
   logic              addr_full;
   logic              scrub_we;
   logic              restart;
   logic              flag_hit;
   logic              timeout_hit;

`ifdef BOOT_SCRUB_EN
   localparam boot_state_e START_ST = ST_SCRUB;
   assign scrub_we = (state == ST_SCRUB);
`else
   localparam boot_state_e START_ST = ST_LOAD;
   assign scrub_we = 1'b0;
`endif

   assign ld_accept = outs.ld_ready && ld_valid_i;
   assign addr_full = (addr_cnt == ADDR_LAST);
   assign restart   = start_i && (state inside {ST_IDLE, ST_DONE, ST_TIMEOUT});

   assign imem_we_o    = ld_accept || scrub_we;
   assign imem_addr_o  = imem_we_o ? addr_cnt : '0;
   assign imem_wdata_o = scrub_we ? NOP_INSTR : (ld_accept ? ld_data_i : '0);

   assign ld_ready_o     = outs.ld_ready;
   assign core_rst_no    = outs.core_rst_n;
   assign fetch_enable_o = outs.fetch_en;
   assign busy_o         = outs.busy;
   assign done_o         = outs.done;
   assign timeout_o      = outs.timeout;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         outs     <= boot_outs(ST_IDLE);
         addr_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
               if (start_i) begin
                  state    <= START_ST;
                  outs     <= boot_outs(START_ST);
                  addr_cnt <= '0;
               end
            end
`ifdef BOOT_SCRUB_EN
            ST_SCRUB: begin
               if (addr_full) begin
                  state    <= ST_LOAD;
                  outs     <= boot_outs(ST_LOAD);
                  addr_cnt <= '0;
               end else begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
               end
            end
`endif
            ST_LOAD: begin
               if (ld_accept) begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
                  // No wrap: a full memory ends the load even without ld_last_i.
                  if (ld_last_i || addr_full) begin
                     state <= ST_RELEASE;
                     outs  <= boot_outs(ST_RELEASE);
                  end
               end
            end
            ST_RELEASE: begin
               state <= ST_RUN;
               outs  <= boot_outs(ST_RUN);
            end
            ST_RUN: begin
               if (flag_hit) begin
                  state <= ST_DONE;
                  outs  <= boot_outs(ST_DONE);
               end else if (timeout_hit) begin
                  state <= ST_TIMEOUT;
                  outs  <= boot_outs(ST_TIMEOUT);
               end
            end
            default: begin
               state <= ST_IDLE;
               outs  <= boot_outs(ST_IDLE);
            end
         endcase
      end
   end

   boot_run_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_run_timer (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .clr_cnt_i     (state == ST_RELEASE),
      .clr_cap_i     (restart),
      .run_i         (state == ST_RUN),
      .mem_flag_i    (mem_flag_i),
      .mem_result_i  (mem_result_i),
      .flag_hit_o    (flag_hit),
      .timeout_hit_o (timeout_hit),
      .result_o      (result_o),
      .cycles_o      (cycles_o)
   );

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Scoreboard bench for soc_boot_ctrl: expected imem writes and run outcomes are queued by the
// stimulus and checked by an independent monitor on the falling clock edge.
`timescale 1ns/1ps
module tb_soc_boot_ctrl;

   localparam int IMEM_DEPTH     = 256;
   localparam int ADDR_W         = 8;
   localparam int TIMEOUT_CYCLES = 100;

   logic              clk_i = 1'b0;
   logic              rst_i, start_i, ld_valid_i, ld_last_i;
   logic [31:0]       ld_data_i, mem_flag_i, mem_result_i;
   logic              ld_ready_o, imem_we_o, core_rst_no, fetch_enable_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_wdata_o, result_o, cycles_o;
   logic              busy_o, done_o, timeout_o;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct { int addr; logic [31:0] data; } wr_t;
   typedef struct { bit is_to; logic [31:0] result; logic [31:0] cycles; } end_t;
   wr_t  wr_q[$];
   end_t end_q[$];

   soc_boot_ctrl #(
      .IMEM_DEPTH(IMEM_DEPTH), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
      .ld_ready_o(ld_ready_o), .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
      .imem_wdata_o(imem_wdata_o), .core_rst_no(core_rst_no), .fetch_enable_o(fetch_enable_o),
      .mem_flag_i(mem_flag_i), .mem_result_i(mem_result_i), .busy_o(busy_o),
      .done_o(done_o), .timeout_o(timeout_o), .result_o(result_o), .cycles_o(cycles_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Monitor: every imem write and every entry into DONE/TIMEOUT is matched against the queues.
   wr_t  mon_w;
   end_t mon_e;
   logic prev_end = 1'b0;
   always @(negedge clk_i) begin
      if (imem_we_o === 1'b1) begin
         if (wr_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0d data %0h with no write expected",
                     imem_addr_o, imem_wdata_o);
         end else begin
            mon_w = wr_q.pop_front();
            check("write_addr", 32'(imem_addr_o), 32'(mon_w.addr));
            check("write_data", imem_wdata_o, mon_w.data);
         end
      end
      if ((done_o === 1'b1 || timeout_o === 1'b1) && prev_end !== 1'b1) begin
         if (end_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_end: done %0b timeout %0b", done_o, timeout_o);
         end else begin
            mon_e = end_q.pop_front();
            check("end_done", 32'(done_o), 32'(!mon_e.is_to));
            check("end_timeout", 32'(timeout_o), 32'(mon_e.is_to));
            check("end_result", result_o, mon_e.result);
            check("end_cycles", cycles_o, mon_e.cycles);
            check("end_fetch_off", 32'(fetch_enable_o), 32'd0);
            check("end_core_rst_n", 32'(core_rst_no), 32'd1);
         end
      end
      prev_end = done_o | timeout_o;
   end

   task automatic check_idle(input string tag);
      check({tag, "_ld_ready"}, 32'(ld_ready_o), 0);
      check({tag, "_imem_we"}, 32'(imem_we_o), 0);
      check({tag, "_imem_addr"}, 32'(imem_addr_o), 0);
      check({tag, "_imem_wdata"}, imem_wdata_o, 0);
      check({tag, "_core_rst_n"}, 32'(core_rst_no), 0);
      check({tag, "_fetch"}, 32'(fetch_enable_o), 0);
      check({tag, "_busy"}, 32'(busy_o), 0);
      check({tag, "_done"}, 32'(done_o), 0);
      check({tag, "_timeout"}, 32'(timeout_o), 0);
      check({tag, "_result"}, result_o, 0);
      check({tag, "_cycles"}, cycles_o, 0);
   endtask

   task automatic reset_pulse(input string tag);
      rst_i = 1'b1; start_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0; mem_flag_i = '0;
      tick();
      rst_i = 1'b0;
      check_idle(tag);
   endtask

   task automatic do_start();
      int k;
`ifdef BOOT_SCRUB_EN
      for (int a = 0; a < IMEM_DEPTH; a++) wr_q.push_back('{a, 32'h0000_0013});
`endif
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("start_result_cleared", result_o, 0);
      check("start_cycles_cleared", cycles_o, 0);
      check("start_busy", 32'(busy_o), 1);
      k = 0;
      while (ld_ready_o !== 1'b1 && k < IMEM_DEPTH + 20) begin
         tick();
         k++;
      end
`ifdef BOOT_SCRUB_EN
      check("scrub_length", 32'(k), 32'(IMEM_DEPTH));
`else
      check("ld_ready_after_start", 32'(k), 0);
`endif
   endtask

   task automatic load_image(input int n, input bit use_last);
      for (int i = 0; i < n; i++) begin
         ld_valid_i = 1'b0;
         repeat ($urandom_range(0, 2)) tick();
         ld_data_i  = $urandom;
         ld_valid_i = 1'b1;
         ld_last_i  = use_last && (i == n - 1);
         if (i < IMEM_DEPTH) wr_q.push_back('{i, ld_data_i});
         tick();
      end
      ld_valid_i = 1'b0;
      ld_last_i  = 1'b0;
   endtask

   // Entered one cycle after the last accepted word; leaves in RUN cycle 1.
   task automatic release_check(input bit extra_word);
      check("release_ld_ready", 32'(ld_ready_o), 0);
      check("release_core_rst_n", 32'(core_rst_no), 1);
      check("release_fetch", 32'(fetch_enable_o), 0);
      if (extra_word) begin
         ld_valid_i = 1'b1;
         ld_data_i  = $urandom;
      end
      tick();
      ld_valid_i = 1'b0;
      check("run_fetch", 32'(fetch_enable_o), 1);
      check("run_core_rst_n", 32'(core_rst_no), 1);
   endtask

   // flag_at: RUN cycle (1-based) on which the flag is raised; 0 means never.
   task automatic run_phase(input int flag_at, input logic [31:0] flag_val, input logic [31:0] res_val);
      logic [31:0] exp_res, exp_cyc;
      bit          exp_to;
      exp_to  = !(flag_at >= 1 && flag_at <= TIMEOUT_CYCLES);
      exp_res = exp_to ? 32'd0 : res_val;
      exp_cyc = exp_to ? 32'(TIMEOUT_CYCLES) : 32'(flag_at);
      end_q.push_back('{exp_to, exp_res, exp_cyc});
      for (int c = 1; c <= TIMEOUT_CYCLES; c++) begin
         mem_result_i = (c == flag_at) ? res_val : $urandom;
         mem_flag_i   = (c == flag_at) ? flag_val : 32'd0;
         tick();
         if (c == flag_at) break;
      end
      mem_flag_i = '0;
      mem_result_i = $urandom;
      tick();
      check("hold_result", result_o, exp_res);
      check("hold_cycles", cycles_o, exp_cyc);
      check("hold_busy", 32'(busy_o), 0);
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; ld_valid_i = 1'b0; ld_last_i = 1'b0;
      ld_data_i = '0; mem_flag_i = '0; mem_result_i = '0;
      tick();
      tick();
      rst_i = 1'b0;
      check_idle("reset");

      // 3-word image, flag with result 55 on the 10th RUN cycle
      do_start(); load_image(3, 1); release_check(0); run_phase(10, 32'd1, 32'd55);

      // flag never raised: timeout after TIMEOUT_CYCLES
      do_start(); load_image($urandom_range(1, 6), 1); release_check(0);
      run_phase(0, 32'd0, 32'd0);

      // flag on the terminal cycle wins over the timeout
      do_start(); load_image(2, 1); release_check(0);
      run_phase(TIMEOUT_CYCLES, $urandom | 32'h8000_0000, $urandom);

      // full memory without ld_last_i; a 257th word is offered during RELEASE
      do_start(); load_image(IMEM_DEPTH, 0); release_check(1);
      run_phase($urandom_range(1, 20), 32'd4, $urandom);

      // reset mid-LOAD, then restart from address 0
      do_start(); load_image(2, 0);
      reset_pulse("midload");
      do_start(); load_image(4, 1); release_check(0);
      repeat (3) tick();
      reset_pulse("midrun");

      // first-cycle flag, then a few randomized runs
      do_start(); load_image(5, 1); release_check(0); run_phase(1, 32'd1, $urandom);
      for (int r = 0; r < 4; r++) begin
         do_start();
         load_image($urandom_range(1, 12), 1);
         release_check(0);
         run_phase($urandom_range(0, TIMEOUT_CYCLES + 5), $urandom | 32'd1, $urandom);
      end

      tick();
      check("writes_outstanding", 32'(wr_q.size()), 0);
      check("ends_outstanding", 32'(end_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
